// File: rtl/disp_pkg.sv
// Shared definitions for the display scan multiplexer: default sizes, the
// scan state encoding and the active-low digit select helper.
package disp_pkg;

    localparam int NUM_DIGITS_DEF  = 4;
    localparam int DIGIT_W_DEF     = 1;
    localparam int REFRESH_DIV_DEF = 50000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

    // Anode pattern for up to 8 digits; callers keep the low NUM_DIGITS bits.
    function automatic logic [7:0] onehot_low(input logic [2:0] idx);
        return ~(8'd1 << idx);
    endfunction

endpackage

// File: rtl/disp_scan_mux_if.sv
// Display-word update port between a producer and the scan multiplexer.
interface disp_scan_mux_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 1
);
    // A word moves on a rising clock edge where upd_valid && upd_ready.
    // upd_data/upd_blank are sampled only on that edge; upd_ready does not
    // depend on upd_valid in the same cycle.
    logic                          upd_valid;
    logic                          upd_ready;
    logic [NUM_DIGITS*DIGIT_W-1:0] upd_data;
    logic [NUM_DIGITS-1:0]         upd_blank;

    modport master (output upd_valid, output upd_data, output upd_blank, input upd_ready);
    modport slave  (input upd_valid, input upd_data, input upd_blank, output upd_ready);
endinterface

// File: rtl/disp_prescaler.sv
// Modulo-DIV counter with enable and synchronous clear; tick_o marks the
// last count of each period so the next enabled cycle restarts at zero.
module disp_prescaler #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign tick_o = en_i && !clr_i && (cnt_q == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= tick_o ? '0 : cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/disp_scan_mux.sv
// Time-multiplexed seven-segment scan controller. New display words are
// parked in a pending buffer and only become visible at a frame boundary.
module disp_scan_mux
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS  = NUM_DIGITS_DEF,
    parameter int DIGIT_W     = DIGIT_W_DEF,
    parameter int REFRESH_DIV = REFRESH_DIV_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scan_en,
    disp_scan_mux_if.slave        upd,
    output logic                  dec_en,
    output logic [DIGIT_W-1:0]    dec_digit,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic                  frame_done,
    output scan_state_e           state_o
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = NUM_DIGITS * DIGIT_W;

    logic                  tick;
    logic                  frame_boundary;
    logic                  xfer;
    logic                  commit;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  pending_full_q, pending_full_d;
    logic                  upd_ready_q;
    logic [DW-1:0]         active_q, pend_data_q;
    logic [NUM_DIGITS-1:0] active_mask_q, pend_mask_q;
    logic [NUM_DIGITS-1:0] an_n_q;
    logic                  dec_en_q;
    logic [DIGIT_W-1:0]    dec_digit_q;
    logic                  frame_done_q;
    scan_state_e           state_q;
    logic                  lit_cur;

    disp_prescaler #(.DIV(REFRESH_DIV)) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (scan_en),
        .clr_i  (!scan_en),
        .tick_o (tick)
    );

    assign frame_boundary = tick && (idx_q == IW'(NUM_DIGITS - 1));
    assign xfer           = upd.upd_valid && upd_ready_q;
    // A word accepted on the boundary cycle waits for the next boundary.
    assign commit         = frame_boundary && pending_full_q;
    assign lit_cur        = scan_en && !active_mask_q[idx_q];

    always_comb begin
        idx_d = idx_q;
        if (!scan_en) begin
            idx_d = '0;
        end else if (tick) begin
            idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        pending_full_d = pending_full_q;
        if (commit) pending_full_d = 1'b0;
        if (xfer)   pending_full_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            pending_full_q <= 1'b0;
            upd_ready_q    <= 1'b1;
            active_q       <= '0;
            active_mask_q  <= '1;
            pend_data_q    <= '0;
            pend_mask_q    <= '1;
            an_n_q         <= '1;
            dec_en_q       <= 1'b0;
            dec_digit_q    <= '0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= scan_en ? ST_SCAN : ST_IDLE;
            idx_q          <= idx_d;
            pending_full_q <= pending_full_d;
            upd_ready_q    <= !pending_full_d;
            if (commit) begin
                active_q      <= pend_data_q;
                active_mask_q <= pend_mask_q;
            end
            if (xfer) begin
                pend_data_q <= upd.upd_data;
                pend_mask_q <= upd.upd_blank;
            end
            an_n_q       <= lit_cur ? NUM_DIGITS'(onehot_low(3'(idx_q))) : '1;
            dec_en_q     <= lit_cur;
            dec_digit_q  <= active_q[idx_q * DIGIT_W +: DIGIT_W];
            frame_done_q <= frame_boundary;
        end
    end

    assign upd.upd_ready = upd_ready_q;
    assign an_n          = an_n_q;
    assign dec_en        = dec_en_q;
    assign dec_digit     = dec_digit_q;
    assign frame_done    = frame_done_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_disp_scan_mux.sv
// Bench for disp_scan_mux with 4 digits, 1-bit digits and a 4-cycle refresh.
module tb_disp_scan_mux;
  import disp_pkg::*;

  localparam int ND  = 4;
  localparam int DW  = 1;
  localparam int DIV = 4;
  localparam int FRAME = ND * DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scan_en = 1'b0;
  logic dec_en;
  logic [DW-1:0] dec_digit;
  logic [ND-1:0] an_n;
  logic frame_done;
  scan_state_e state_o;

  int n_checks = 0;
  int n_fail = 0;

  disp_scan_mux_if #(.NUM_DIGITS(ND), .DIGIT_W(DW)) upd_if ();

  disp_scan_mux #(.NUM_DIGITS(ND), .DIGIT_W(DW), .REFRESH_DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_en    (scan_en),
    .upd        (upd_if.slave),
    .dec_en     (dec_en),
    .dec_digit  (dec_digit),
    .an_n       (an_n),
    .frame_done (frame_done),
    .state_o    (state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // model: display position derived from count of consecutive scanning cycles
  logic [ND-1:0] m_active = '0;
  logic [ND-1:0] m_mask = '1;
  logic [2*ND-1:0] exp_q[$];
  logic m_ready = 1'b1;
  int en_cycles = 0;
  logic [ND-1:0] e_an = '1;
  logic e_den = 1'b0;
  logic e_dig = 1'b0;
  logic e_fd = 1'b0;
  logic e_ready = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = '0; m_mask = '1; exp_q.delete(); m_ready = 1'b1; en_cycles = 0;
      e_an = '1; e_den = 1'b0; e_dig = 1'b0; e_fd = 1'b0; e_ready = 1'b1;
    end else begin
      int phase, pos;
      logic boundary, xfer, commit;
      logic [2*ND-1:0] w;
      phase = en_cycles % FRAME;
      pos = phase / DIV;
      boundary = scan_en && (phase == FRAME - 1);
      e_den = scan_en && !m_mask[pos];
      e_an = e_den ? ~(ND'(1) << pos) : '1;
      e_dig = m_active[pos];
      e_fd = boundary;
      commit = boundary && (exp_q.size() != 0);
      xfer = upd_if.upd_valid && m_ready;
      if (commit) begin
        w = exp_q.pop_front();
        m_mask = w[2*ND-1:ND];
        m_active = w[ND-1:0];
      end
      if (xfer) exp_q.push_back({upd_if.upd_blank, upd_if.upd_data});
      m_ready = (exp_q.size() == 0);
      e_ready = m_ready;
      en_cycles = scan_en ? en_cycles + 1 : 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // scoreboard compare every cycle
  always @(negedge clk) begin
    chk("an_n", 32'(an_n), 32'(e_an));
    chk("dec_en", 32'(dec_en), 32'(e_den));
    chk("dec_digit", 32'(dec_digit), 32'(e_dig));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("upd_ready", 32'(upd_if.upd_ready), 32'(e_ready));
  end

  // driver tasks
  task automatic send_word(input logic [ND-1:0] data, input logic [ND-1:0] blank);
    upd_if.upd_valid = 1'b1;
    upd_if.upd_data = data;
    upd_if.upd_blank = blank;
    @(negedge clk);
    upd_if.upd_valid = 1'b0;
  endtask

  task automatic wait_fd(input int max_cycles);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < max_cycles);
    if (frame_done !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL wait_frame_done: no pulse within %0d cycles", max_cycles);
    end
  endtask

  task automatic wait_ready(input int max_cycles);
    int n = 0;
    while (upd_if.upd_ready !== 1'b1 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (upd_if.upd_ready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL wait_ready: not ready within %0d cycles", max_cycles);
    end
  endtask

  logic [ND-1:0] an_tbl[ND] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [ND-1:0] word_a = 4'b1010;

  initial begin
    upd_if.upd_valid = 1'b0;
    upd_if.upd_data = '0;
    upd_if.upd_blank = '0;
    repeat (3) @(negedge clk);
    chk("rst_an_n", 32'(an_n), 32'hF);
    chk("rst_dec_en", 32'(dec_en), 32'h0);
    chk("rst_ready", 32'(upd_if.upd_ready), 32'h1);
    rst_n = 1'b1;
    @(negedge clk);

    // scan order with word 1010, no blanking
    send_word(4'b1010, 4'b0000);
    chk("ready_drop", 32'(upd_if.upd_ready), 32'h0);
    scan_en = 1'b1;
    wait_fd(100);
    chk("ready_after_commit", 32'(upd_if.upd_ready), 32'h1);
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      chk("lit_an_seq", 32'(an_n), 32'(an_tbl[(k-1)/DIV]));
      chk("lit_digit_seq", 32'(dec_digit), 32'(word_a[(k-1)/DIV]));
      chk("lit_fd_period", 32'(frame_done), (k == FRAME) ? 32'h1 : 32'h0);
    end

    // tear-free update offered while digit 1 is selected
    repeat (4) @(negedge clk);
    send_word(4'b1111, 4'b0000);
    chk("lit_tear_ready_drop", 32'(upd_if.upd_ready), 32'h0);
    wait_fd(100);
    @(negedge clk);
    chk("lit_tear_new_digit0", 32'(dec_digit), 32'h1);

    // backpressure: hold a second word until the first has committed
    repeat (3) @(negedge clk);
    upd_if.upd_valid = 1'b1;
    upd_if.upd_data = 4'b0011;
    upd_if.upd_blank = 4'b0000;
    @(negedge clk);
    upd_if.upd_data = 4'b0101;
    wait_ready(200);
    @(negedge clk);
    upd_if.upd_valid = 1'b0;

    // blanking digit 2
    wait_ready(200);
    send_word(4'b0000, 4'b0100);
    wait_fd(100);
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      chk("lit_blank_an", 32'(an_n), ((k-1)/DIV == 2) ? 32'hF : 32'(an_tbl[(k-1)/DIV]));
      chk("lit_blank_den", 32'(dec_en), ((k-1)/DIV == 2) ? 32'h0 : 32'h1);
    end

    // scan_en low for 10 cycles mid-frame
    repeat (6) @(negedge clk);
    scan_en = 1'b0;
    @(negedge clk);
    chk("lit_off_an", 32'(an_n), 32'hF);
    chk("lit_off_den", 32'(dec_en), 32'h0);
    repeat (9) @(negedge clk);
    scan_en = 1'b1;
    for (int k = 1; k <= DIV + 1; k++) begin
      @(negedge clk);
      chk("lit_restart_an", 32'(an_n), (k <= DIV) ? 32'hE : 32'hD);
    end

    // reset with a pending word in flight
    wait_ready(200);
    send_word(4'b0110, 4'b0000);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_midrst_an", 32'(an_n), 32'hF);
    chk("lit_midrst_den", 32'(dec_en), 32'h0);
    chk("lit_midrst_ready", 32'(upd_if.upd_ready), 32'h1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2 * FRAME) @(negedge clk);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      scan_en = ($urandom_range(0, 19) != 0);
      upd_if.upd_valid = ($urandom_range(0, 3) == 0);
      upd_if.upd_data = ND'($urandom_range(0, 15));
      upd_if.upd_blank = ND'($urandom_range(0, 15));
      @(negedge clk);
    end
    upd_if.upd_valid = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/disp_scan_mux.md
Name: disp_scan_mux

Overview:
- Time-multiplexed scan controller directly upstream of the seven-segment decoder in the register-based instruction processor.
- Holds an N-digit display word, cycles one digit at a time, and drives the decoder's enable and digit value plus the active-low digit anodes.
- Accepts new display words through a valid/ready handshake. A new word takes effect only at a frame boundary, so the display never shows a mix of old and new digits (no tearing).

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- DIGIT_W, 1, width of each digit value passed to the decoder.
- REFRESH_DIV, 50000, clock cycles each digit stays selected (>=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- scan_en  in  1  1 = scanning; 0 = display dark, counters held.
- upd_valid  in  1  producer offers a new display word.
- upd_ready  out  1  block can accept a word.
- upd_data  in  NUM_DIGITS*DIGIT_W  packed digits; digit 0 in the LSBs.
- upd_blank  in  NUM_DIGITS  per-digit blank mask (1 = digit dark), captured with upd_data.
- dec_en  out  1  drives the decoder enable.
- dec_digit  out  DIGIT_W  drives the decoder input.
- an_n  out  NUM_DIGITS  active-low digit select, one-hot-low.
- frame_done  out  1  one-cycle pulse when the last digit's slot ends.

Behaviour:
- Reset values (async assert, sync release):
  - prescaler=0, idx=0, active word=0, active mask=all 1s, pending_full=0.
  - an_n=all 1s, dec_en=0, dec_digit=0, upd_ready=1, frame_done=0.
- Prescaler: counts 0..REFRESH_DIV-1 while scan_en=1. tick = (prescaler==REFRESH_DIV-1), after which it wraps to 0.
- Index: idx advances on tick and wraps NUM_DIGITS-1 -> 0. frame_boundary = tick && idx==NUM_DIGITS-1.
- Handshake:
  - Transfer occurs when upd_valid && upd_ready; upd_data and upd_blank are then latched into the pending registers and pending_full is set.
  - upd_ready = !pending_full (registered).
  - upd_data is don't-care when no transfer occurs.
- Commit:
  - On frame_boundary with pending_full=1: pending copies to active and pending_full clears. upd_ready returns to 1 the next cycle.
  - If a transfer and a frame_boundary happen in the same cycle, the new word goes to pending and commits at the next boundary. No bypass.
- Outputs (all registered, one cycle after idx/active change):
  - an_n = ~(1<<idx) when scan_en=1 and active mask[idx]=0; otherwise all 1s.
  - dec_en = scan_en && !mask[idx].
  - dec_digit = active[idx] (held even when blanked).
- frame_done: 1 in the cycle after frame_boundary, regardless of commit.
- scan_en=0:
  - prescaler and idx are forced to 0; outputs go dark on the next cycle.
  - The handshake still works. A pending word commits at the first frame_boundary after scan_en returns to 1.
- Reset mid-frame or mid-handshake: all state returns to the reset values immediately and any pending word is discarded.
- States: SCAN (scan_en=1) and IDLE (scan_en=0). pending_full is an orthogonal 1-bit EMPTY/FULL flag.

Decomposition:
- Shared package disp_pkg:
  - localparam defaults for NUM_DIGITS, DIGIT_W, REFRESH_DIV.
  - function onehot_low(idx) returning the an_n pattern.
- One natural sub-module: disp_prescaler (parameterised modulo counter with enable, sync clear and tick output), reusable for other refresh timers.
- Existing seven-segment decoder instantiated by the integrating top, not inside this block.

Test Plan:
- Reset: REFRESH_DIV=4, NUM_DIGITS=4, rst_n low mid-run -> an_n=4'b1111, dec_en=0, upd_ready=1 within the same cycle.
- Scan order: commit word 4'b1010 with mask 0, scan_en=1 -> an_n sequence 1110,1101,1011,0111, each held 4 cycles; dec_digit sequence 0,1,0,1; frame_done pulses every 16 cycles.
- Tear-free update: send 4'b1111 while idx=1 -> upd_ready drops the next cycle; digits 2..3 still show old values; new value appears from idx=0 of the next frame; upd_ready=1 after the commit.
- Backpressure: second upd_valid while pending_full -> no transfer; data accepted only after the boundary; the first word is never lost.
- Blanking: upd_blank=4'b0100 -> during idx=2 an_n=1111 and dec_en=0; other digits normal.
- scan_en low for 10 cycles mid-frame -> an_n=1111 and dec_en=0 from the next cycle; on re-enable, scanning restarts at idx=0 with prescaler 0.
